// File: rtl/pet_prg_loader.sv
// PET .PRG download loader: streams payload bytes into RAM over the DMA port and then
// patches the BASIC 4 end-of-program pointers so the loaded program can be RUN directly.
module pet_prg_loader #(
    parameter logic [15:0] PTR_BASE = 16'h002A,
    parameter int unsigned NUM_PTRS = 3,
    parameter logic [15:0] RAM_TOP  = 16'h8000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_data,
    output logic        ioctl_wait,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_din,
    output logic        dma_we,
    output logic        busy,
    output logic        err_range,
    output logic        err_short
);

    localparam int unsigned NumWr = 2 * NUM_PTRS;
    localparam int unsigned CntW  = (NumWr < 2) ? 1 : $clog2(NumWr + 1);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StHdrLo = 3'd1;
    localparam logic [2:0] StHdrHi = 3'd2;
    localparam logic [2:0] StData  = 3'd3;
    localparam logic [2:0] StFix   = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

    logic [2:0]      state_q, state_d;
    logic            dl_q;
    logic [7:0]      load_lo_q, load_lo_d;
    logic [15:0]     cur_q, cur_d;
    logic [15:0]     end_q, end_d;
    logic            wrap_q, wrap_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [15:0]     addr_q, addr_d;
    logic [7:0]      din_q, din_d;
    logic            err_range_q, err_range_d;
    logic            err_short_q, err_short_d;

    logic dl_rise;
    logic dl_fall;

    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;

    always_comb begin
        state_d     = state_q;
        load_lo_d   = load_lo_q;
        cur_d       = cur_q;
        end_d       = end_q;
        wrap_d      = wrap_q;
        cnt_d       = cnt_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        din_d       = din_q;
        err_range_d = err_range_q;
        err_short_d = err_short_q;

        // A new download always wins, whatever was in progress.
        if (dl_rise) begin
            state_d     = StHdrLo;
            err_range_d = 1'b0;
            err_short_d = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StHdrLo: begin
                    if (dl_fall) begin
                        err_short_d = 1'b1;
                        state_d     = StIdle;
                    end else if (ioctl_wr) begin
                        load_lo_d = ioctl_data;
                        state_d   = StHdrHi;
                    end
                end
                StHdrHi: begin
                    if (dl_fall) begin
                        err_short_d = 1'b1;
                        state_d     = StIdle;
                    end else if (ioctl_wr) begin
                        cur_d   = {ioctl_data, load_lo_q};
                        end_d   = {ioctl_data, load_lo_q};
                        wrap_d  = 1'b0;
                        state_d = StData;
                    end
                end
                StData: begin
                    if (dl_fall) begin
                        cnt_d   = '0;
                        state_d = err_range_q ? StDone : StFix;
                    end else if (ioctl_wr) begin
                        if (wrap_q || (cur_q >= RAM_TOP)) begin
                            err_range_d = 1'b1;
                        end else begin
                            we_d   = 1'b1;
                            addr_d = cur_q;
                            din_d  = ioctl_data;
                            end_d  = cur_q + 16'd1;
                        end
                        // Once the address has wrapped, the rest of the stream is dropped.
                        if (cur_q == 16'hFFFF) begin
                            wrap_d      = 1'b1;
                            err_range_d = 1'b1;
                        end
                        cur_d = cur_q + 16'd1;
                    end
                end
                StFix: begin
                    if (cnt_q == CntW'(NumWr)) begin
                        state_d = StDone;
                    end else begin
                        we_d   = 1'b1;
                        addr_d = PTR_BASE + 16'(cnt_q);
                        din_d  = cnt_q[0] ? end_q[15:8] : end_q[7:0];
                        cnt_d  = cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            dl_q        <= 1'b0;
            load_lo_q   <= 8'h00;
            cur_q       <= 16'h0000;
            end_q       <= 16'h0000;
            wrap_q      <= 1'b0;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= 16'h0000;
            din_q       <= 8'h00;
            err_range_q <= 1'b0;
            err_short_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dl_q        <= ioctl_download;
            load_lo_q   <= load_lo_d;
            cur_q       <= cur_d;
            end_q       <= end_d;
            wrap_q      <= wrap_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            err_range_q <= err_range_d;
            err_short_q <= err_short_d;
        end
    end

    assign dma_we     = we_q;
    assign dma_addr   = addr_q;
    assign dma_din    = din_q;
    assign err_range  = err_range_q;
    assign err_short  = err_short_q;
    assign ioctl_wait = (state_q == StFix);
    assign busy       = (state_q == StHdrLo) || (state_q == StHdrHi) ||
                        (state_q == StData)  || (state_q == StFix);

endmodule

// File: tb/tb_pet_prg_loader.sv
// Bench for pet_prg_loader: directed and random .PRG downloads checked against a
// list-of-writes reference model built from the load address and payload bytes.
module tb_pet_prg_loader;

    localparam int PTR_BASE_I = 16'h002A;
    localparam int NUM_PTRS_I = 3;
    localparam int RAM_TOP_I  = 16'h8000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wait;
    logic [15:0] dma_addr;
    logic [7:0]  dma_din;
    logic        dma_we;
    logic        busy;
    logic        err_range;
    logic        err_short;

    pet_prg_loader dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_data     (ioctl_data),
        .ioctl_wait     (ioctl_wait),
        .dma_addr       (dma_addr),
        .dma_din        (dma_din),
        .dma_we         (dma_we),
        .busy           (busy),
        .err_range      (err_range),
        .err_short      (err_short)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] mon_addr[$];
    logic [7:0]  mon_data[$];
    logic        mon_wait[$];
    int          mon_cyc[$];

    logic [15:0] exp_addr[$];
    logic [7:0]  exp_data[$];
    logic        exp_wait[$];
    logic        exp_err;

    logic [7:0]  pay[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dma_we === 1'b1) begin
            mon_addr.push_back(dma_addr);
            mon_data.push_back(dma_din);
            mon_wait.push_back(ioctl_wait);
            mon_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] b, input int gap);
        ioctl_wr   = 1'b1;
        ioctl_data = b;
        tick(1);
        ioctl_wr   = 1'b0;
        ioctl_data = $urandom_range(0, 255);
        tick(gap - 1);
    endtask

    // Expected writes: payload byte i lands at la+i unless that is at/above RAM_TOP
    // (counted without wrapping), then pointer fixup with last-written+1 when error-free.
    task automatic build_model(input int la);
        int a;
        int last_end;
        exp_addr.delete();
        exp_data.delete();
        exp_wait.delete();
        exp_err  = 1'b0;
        last_end = la;
        for (int i = 0; i < pay.size(); i++) begin
            a = la + i;
            if (a < RAM_TOP_I) begin
                exp_addr.push_back(a[15:0]);
                exp_data.push_back(pay[i]);
                exp_wait.push_back(1'b0);
                last_end = a + 1;
            end else begin
                exp_err = 1'b1;
            end
        end
        if (!exp_err) begin
            for (int k = 0; k < 2 * NUM_PTRS_I; k++) begin
                exp_addr.push_back(16'(PTR_BASE_I + k));
                exp_data.push_back((k % 2) ? last_end[15:8] : last_end[7:0]);
                exp_wait.push_back(1'b1);
            end
        end
    endtask

    task automatic run_dl(input int la, input int gap, input bit fix_strobe, input bit chk_fast);
        int  n;
        bit  ok;
        int  a;
        mon_addr.delete();
        mon_data.delete();
        mon_wait.delete();
        mon_cyc.delete();
        build_model(la);

        ioctl_download = 1'b1;
        tick(2);
        check("busy_start", busy, 1'b1);
        check("err_clr", {err_range, err_short}, 2'b00);
        strobe(la[7:0], gap);
        strobe(la[15:8], gap);
        for (int i = 0; i < pay.size(); i++) begin
            a  = la + i;
            ok = (a < RAM_TOP_I);
            ioctl_wr   = 1'b1;
            ioctl_data = pay[i];
            tick(1);
            ioctl_wr   = 1'b0;
            check("we_latency", dma_we, ok);
            if (ok) check("we_addr", dma_addr, a[15:0]);
            tick(gap - 1);
        end

        ioctl_download = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            tick(1);
            n++;
            if (fix_strobe && n == 3) begin
                check("wait_in_fix", ioctl_wait, 1'b1);
                ioctl_wr   = 1'b1;
                ioctl_data = 8'h5A;
            end else begin
                ioctl_wr = 1'b0;
            end
        end
        ioctl_wr = 1'b0;
        check("busy_end", busy, 1'b0);
        if (chk_fast) check("busy_fast", (n <= 2), 1'b1);
        tick(2);

        check("err_range", err_range, exp_err);
        check("err_short", err_short, 1'b0);
        check("wait_idle", ioctl_wait, 1'b0);
        check("n_writes", mon_addr.size(), exp_addr.size());
        if (mon_addr.size() == exp_addr.size()) begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                check("wr_addr", mon_addr[i], exp_addr[i]);
                check("wr_data", mon_data[i], exp_data[i]);
                check("wr_wait", mon_wait[i], exp_wait[i]);
                if (exp_wait[i] && i > 0 && exp_wait[i-1])
                    check("fix_consec", mon_cyc[i] - mon_cyc[i-1], 1);
            end
        end
    endtask

    initial begin
        int la;
        int len;
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_data     = 8'h00;
        tick(2);
        check("rst_outs", {ioctl_wait, dma_we, busy, err_range, err_short}, 5'b0);
        check("rst_addr", {dma_addr, dma_din}, 24'h0);
        reset_n = 1'b1;
        tick(2);

        // Basic payload with pointer fixup.
        pay = '{8'hAA, 8'hBB, 8'hCC};
        run_dl(16'h0401, 3, 1'b0, 1'b0);

        // Header only: pointers get the load address.
        pay.delete();
        run_dl(16'h0401, 3, 1'b0, 1'b0);

        // Crossing RAM_TOP: no fixup, quick completion.
        pay = '{8'h11, 8'h22, 8'h33};
        run_dl(16'h7FFE, 3, 1'b0, 1'b1);

        // Short download: one header byte only.
        mon_addr.delete();
        ioctl_download = 1'b1;
        tick(2);
        strobe(8'h01, 3);
        ioctl_download = 1'b0;
        tick(1);
        check("short_flag", err_short, 1'b1);
        check("short_busy", busy, 1'b0);
        tick(3);
        check("short_nowr", mon_addr.size(), 0);
        check("short_sticky", {err_short, err_range, ioctl_wait}, 3'b100);

        // Reset while a payload write is on the bus.
        ioctl_download = 1'b1;
        tick(2);
        strobe(8'h00, 3);
        strobe(8'h05, 3);
        ioctl_wr   = 1'b1;
        ioctl_data = 8'h77;
        tick(1);
        ioctl_wr   = 1'b0;
        check("we_pending", {dma_we, dma_addr, dma_din}, {1'b1, 16'h0500, 8'h77});
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_we", {dma_we, busy, ioctl_wait}, 3'b000);
        check("rst_mid_regs", {dma_addr, dma_din, err_range, err_short}, 26'h0);
        ioctl_download = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        pay = '{8'h10, 8'h20, 8'h30};
        run_dl(16'h0500, 3, 1'b0, 1'b0);

        // Strobe arriving during fixup is ignored.
        pay = '{8'hAA, 8'hBB, 8'hCC};
        run_dl(16'h0401, 3, 1'b1, 1'b0);

        // Random downloads, biased toward RAM_TOP and the top of the address space.
        for (int t = 0; t < 10; t++) begin
            case ($urandom_range(0, 3))
                0:       la = $urandom_range(16'h0400, 16'h7000);
                1:       la = RAM_TOP_I - $urandom_range(0, 4);
                2:       la = 16'hFFFF - $urandom_range(0, 2);
                default: la = $urandom_range(0, 16'hFFFF);
            endcase
            len = $urandom_range(0, 6);
            pay.delete();
            for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
            run_dl(la, $urandom_range(2, 4), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
